// File: rtl/draw_pkg.sv
// Shared definitions for the pixel draw path: sequencer states, default
// screen geometry and the two fixed fill colours.
package draw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ARB,
        STREAM,
        FILL,
        OVER
    } state_e;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

    localparam logic [2:0] BG_COLOR   = 3'b000;
    localparam logic [2:0] OVER_COLOR = 3'b100;

endpackage

// File: rtl/rr_picker.sv
// Round-robin request picker: the search starts at rr_ptr and wraps, the
// first requesting channel wins. Purely combinational.
module rr_picker #(
    parameter int N_CH  = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_CH-1:0]  req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_CH-1:0]  grant,
    output logic             valid
);

    // Walk the channels in rotated order and grant the first requester.
    always_comb begin
        int idx;
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_CH; k++) begin
            idx = (int'(rr_ptr) + k) % N_CH;
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_arbiter.sv
// N-channel sprite arbiter and screen sequencer feeding the 160x120 VGA
// adapter plot port: clear sweep, round-robin sprite streaming with
// off-screen clipping, and a game-over fill.
module pixel_arbiter #(
    parameter int N_CH     = 4,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOR_W  = 3,
    parameter int SCREEN_W = draw_pkg::DEF_SCREEN_W,
    parameter int SCREEN_H = draw_pkg::DEF_SCREEN_H,
    parameter logic [COLOR_W-1:0] BG_COLOR   = draw_pkg::BG_COLOR,
    parameter logic [COLOR_W-1:0] OVER_COLOR = draw_pkg::OVER_COLOR
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      game_over,
    input  logic [N_CH-1:0]           req,
    input  logic [N_CH*X_W-1:0]       px_x,
    input  logic [N_CH*Y_W-1:0]       px_y,
    input  logic [N_CH*COLOR_W-1:0]   px_color,
    input  logic [N_CH-1:0]           px_last,
    output logic [N_CH-1:0]           ack,
    output logic [N_CH-1:0]           done,
    output logic                      clear_done,
    output logic                      over_done,
    output logic [X_W-1:0]            oX,
    output logic [Y_W-1:0]            oY,
    output logic [COLOR_W-1:0]        oColor,
    output logic                      writeEn
);

    import draw_pkg::*;

    localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [X_W-1:0]   X_LAST = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0]   Y_LAST = Y_W'(SCREEN_H - 1);
    localparam logic [PTR_W-1:0] CH_LAST = PTR_W'(N_CH - 1);

    state_e               state_q, state_d;
    logic [X_W-1:0]       sx_q, sx_d;
    logic [Y_W-1:0]       sy_q, sy_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [X_W-1:0]       ox_q, ox_d;
    logic [Y_W-1:0]       oy_q, oy_d;
    logic [COLOR_W-1:0]   ocol_q, ocol_d;
    logic                 we_q, we_d;
    logic [N_CH-1:0]      done_q, done_d;
    logic                 clear_done_q, clear_done_d;
    logic                 over_done_q, over_done_d;

    logic [N_CH-1:0]      grant;
    logic                 grant_vld;
    logic [PTR_W-1:0]     grant_idx;
    logic [PTR_W-1:0]     owner_inc;
    logic [X_W-1:0]       cur_x;
    logic [Y_W-1:0]       cur_y;
    logic [COLOR_W-1:0]   cur_c;

    rr_picker #(
        .N_CH  (N_CH),
        .PTR_W (PTR_W)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .grant  (grant),
        .valid  (grant_vld)
    );

    // Current pixel of the owning channel, and the fairness pointer value
    // that follows it.
    assign cur_x     = px_x[int'(owner_q)*X_W +: X_W];
    assign cur_y     = px_y[int'(owner_q)*Y_W +: Y_W];
    assign cur_c     = px_color[int'(owner_q)*COLOR_W +: COLOR_W];
    assign owner_inc = (owner_q == CH_LAST) ? '0 : owner_q + 1'b1;

    // Encode the one-hot grant into a channel number for the owner latch.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) grant_idx = PTR_W'(i);
        end
    end

    // Sequencer next state, sweep counters, plot data and combinational ack.
    always_comb begin
        state_d      = state_q;
        sx_d         = '0;
        sy_d         = '0;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        ox_d         = ox_q;
        oy_d         = oy_q;
        ocol_d       = ocol_q;
        we_d         = 1'b0;
        done_d       = '0;
        clear_done_d = 1'b0;
        over_done_d  = 1'b0;
        ack          = '0;

        case (state_q)
            IDLE: begin
                if (start) state_d = CLEAR;
            end

            CLEAR, FILL: begin
                ox_d   = sx_q;
                oy_d   = sy_q;
                ocol_d = (state_q == CLEAR) ? BG_COLOR : OVER_COLOR;
                we_d   = 1'b1;
                if (sx_q != X_LAST) begin
                    sx_d = sx_q + 1'b1;
                    sy_d = sy_q;
                end else if (sy_q != Y_LAST) begin
                    sy_d = sy_q + 1'b1;
                end else if (state_q == CLEAR) begin
                    // counters fall back to zero via the defaults
                    clear_done_d = 1'b1;
                    state_d      = ARB;
                end else begin
                    over_done_d = 1'b1;
                    state_d     = OVER;
                end
            end

            ARB: begin
                if (game_over) begin
                    state_d = FILL;
                end else if (grant_vld) begin
                    owner_d = grant_idx;
                    state_d = STREAM;
                end
            end

            STREAM: begin
                if (game_over) begin
                    // sprite abandoned: no ack, no done
                    state_d = FILL;
                end else if (!req[owner_q]) begin
                    rr_ptr_d = owner_inc;
                    state_d  = ARB;
                end else begin
                    ack[owner_q] = 1'b1;
                    ox_d   = cur_x;
                    oy_d   = cur_y;
                    ocol_d = cur_c;
                    // off-screen pixels are consumed but never plotted
                    we_d   = (cur_x <= X_LAST) && (cur_y <= Y_LAST);
                    if (px_last[owner_q]) begin
                        done_d[owner_q] = 1'b1;
                        rr_ptr_d        = owner_inc;
                        state_d         = ARB;
                    end
                end
            end

            OVER: begin
                if (start) state_d = CLEAR;
            end

            default: state_d = IDLE;
        endcase
    end

    // State and registered plot outputs; reset clears everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            sx_q         <= '0;
            sy_q         <= '0;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            ox_q         <= '0;
            oy_q         <= '0;
            ocol_q       <= '0;
            we_q         <= 1'b0;
            done_q       <= '0;
            clear_done_q <= 1'b0;
            over_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            ox_q         <= ox_d;
            oy_q         <= oy_d;
            ocol_q       <= ocol_d;
            we_q         <= we_d;
            done_q       <= done_d;
            clear_done_q <= clear_done_d;
            over_done_q  <= over_done_d;
        end
    end

    assign oX         = ox_q;
    assign oY         = oy_q;
    assign oColor     = ocol_q;
    assign writeEn    = we_q;
    assign done       = done_q;
    assign clear_done = clear_done_q;
    assign over_done  = over_done_q;

endmodule

// File: tb/tb_pixel_arbiter.sv
// Directed bench for pixel_arbiter: clear sweep, two-sprite streaming,
// round-robin fairness, clipping, game-over fill and reset mid-sweep.
module tb_pixel_arbiter;

    import draw_pkg::*;

    localparam int N  = 4;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;

    logic              clock = 1'b0;
    logic              reset, start, game_over;
    logic [N-1:0]      req, px_last, ack, done;
    logic [N*XW-1:0]   px_x;
    logic [N*YW-1:0]   px_y;
    logic [N*CW-1:0]   px_color;
    logic              clear_done, over_done, writeEn;
    logic [XW-1:0]     oX;
    logic [YW-1:0]     oY;
    logic [CW-1:0]     oColor;

    int n_assert = 0;
    int n_fail   = 0;

    // Sprite tables: each channel streams tlen entries, advancing on ack.
    logic [XW-1:0] tx [N][16];
    logic [YW-1:0] ty [N][16];
    logic [CW-1:0] tc [N][16];
    logic          tl [N][16];
    int            tlen [N];
    int            idx  [N];
    logic          load;

    pixel_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .game_over  (game_over),
        .req        (req),
        .px_x       (px_x),
        .px_y       (px_y),
        .px_color   (px_color),
        .px_last    (px_last),
        .ack        (ack),
        .done       (done),
        .clear_done (clear_done),
        .over_done  (over_done),
        .oX         (oX),
        .oY         (oY),
        .oColor     (oColor),
        .writeEn    (writeEn)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (load)        idx[i] <= 0;
            else if (ack[i]) idx[i] <= idx[i] + 1;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            int e;
            e = idx[i] & 15;
            req[i]               = (idx[i] < tlen[i]);
            px_x[i*XW +: XW]     = tx[i][e];
            px_y[i*YW +: YW]     = ty[i][e];
            px_color[i*CW +: CW] = tc[i][e];
            px_last[i]           = tl[i][e];
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clear_tables();
        for (int i = 0; i < N; i++) begin
            tlen[i] = 0;
            for (int k = 0; k < 16; k++) begin
                tx[i][k] = '0; ty[i][k] = '0; tc[i][k] = '0; tl[i][k] = 1'b0;
            end
        end
    endtask

    task automatic do_load();
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Called right after the sequencer enters CLEAR/FILL; follows one sweep.
    task automatic sweep_check(input string tag, input logic [2:0] col, input bit is_clear);
        int   nw = 0, cyc = 0, ex = 0, ey = 0, bad_done = 0;
        bit   order_ok = 1'b1, col_ok = 1'b1, pulse_ok = 1'b0, got = 1'b0;
        logic pulse;
        while (!got && cyc < 20000) begin
            tick();
            cyc++;
            pulse = is_clear ? clear_done : over_done;
            if (done != '0) bad_done++;
            if (writeEn) begin
                nw++;
                if (oX !== XW'(ex) || oY !== YW'(ey)) order_ok = 1'b0;
                if (oColor !== col) col_ok = 1'b0;
                ex++;
                if (ex == 160) begin ex = 0; ey++; end
            end
            if (pulse) begin
                got      = 1'b1;
                pulse_ok = writeEn && (oX == 8'd159) && (oY == 7'd119);
            end
        end
        chk({tag, "_writes"},   nw, 19200);
        chk({tag, "_cycles"},   cyc, 19200);
        chk({tag, "_order"},    order_ok, 1);
        chk({tag, "_colour"},   col_ok, 1);
        chk({tag, "_pulse"},    pulse_ok, 1);
        chk({tag, "_no_done"},  bad_done, 0);
        tick();
        chk({tag, "_after_we"}, writeEn, 0);
        chk({tag, "_after_pulse"}, is_clear ? clear_done : over_done, 0);
    endtask

    initial begin
        logic [N-1:0] e_ack, e_done;
        logic         e_we;
        int           grants [8];
        int           ng;
        int           dcnt [N];
        int           nw;

        reset = 1'b1; start = 1'b0; game_over = 1'b0; load = 1'b0;
        clear_tables();

        // Reset state
        repeat (3) tick();
        chk("rst_we",    writeEn, 0);
        chk("rst_ack",   ack, 0);
        chk("rst_done",  done, 0);
        chk("rst_cdone", clear_done, 0);
        chk("rst_odone", over_done, 0);
        chk("rst_pix",   {oX, oY, oColor}, 0);
        chk("rst_state", dut.state_q, IDLE);
        chk("rst_rr",    dut.rr_ptr_q, 0);
        reset = 1'b0;
        tick();
        chk("idle_we", writeEn, 0);

        // Clear sweep
        start = 1'b1;
        tick();
        start = 1'b0;
        sweep_check("clear", 3'b000, 1'b1);

        // Two sprites: ch1 then ch3 with one gap cycle between them
        for (int k = 0; k < 4; k++) begin
            tx[1][k] = XW'(10 + k); ty[1][k] = 7'd20; tc[1][k] = 3'b010; tl[1][k] = (k == 3);
            tx[3][k] = XW'(50 + k); ty[3][k] = 7'd60; tc[3][k] = 3'b011; tl[3][k] = (k == 3);
        end
        do_load();
        tlen[1] = 4; tlen[3] = 4;
        for (int c = 1; c <= 11; c++) begin
            tick();
            e_ack  = (c <= 4) ? 4'b0010 : (c >= 6 && c <= 9) ? 4'b1000 : 4'b0000;
            e_we   = (c >= 2 && c <= 5) || (c >= 7 && c <= 10);
            e_done = (c == 5) ? 4'b0010 : (c == 10) ? 4'b1000 : 4'b0000;
            chk("spr_ack",  ack, e_ack);
            chk("spr_we",   writeEn, e_we);
            chk("spr_done", done, e_done);
            if (e_we)
                chk("spr_pix", {oX, oY, oColor},
                    (c <= 5) ? {XW'(10 + c - 2), 7'd20, 3'b010}
                             : {XW'(50 + c - 7), 7'd60, 3'b011});
        end

        // Fairness: every channel has two 1-pixel sprites
        clear_tables();
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 2; k++) begin
                tx[i][k] = XW'(i * 10 + k); ty[i][k] = 7'd1; tc[i][k] = CW'(i); tl[i][k] = 1'b1;
            end
            dcnt[i] = 0;
        end
        do_load();
        for (int i = 0; i < N; i++) tlen[i] = 2;
        ng = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (ack != '0) begin
                if (ng < 8) grants[ng] = $clog2(ack);
                ng++;
            end
            for (int i = 0; i < N; i++) if (done[i]) dcnt[i]++;
        end
        chk("rr_ngrants", ng, 8);
        chk("rr_g0", grants[0], 0);
        chk("rr_g1", grants[1], 1);
        chk("rr_g2", grants[2], 2);
        chk("rr_g3", grants[3], 3);
        chk("rr_g4", grants[4], 0);
        for (int i = 0; i < N; i++) chk("rr_done_cnt", dcnt[i], 2);

        // Clipping: (170,5) and (8,120) are acked but not plotted
        clear_tables();
        tx[0][0] = 8'd5;   ty[0][0] = 7'd5;
        tx[0][1] = 8'd170; ty[0][1] = 7'd5;
        tx[0][2] = 8'd8;   ty[0][2] = 7'd120;
        tx[0][3] = 8'd7;   ty[0][3] = 7'd5;   tl[0][3] = 1'b1;
        for (int k = 0; k < 4; k++) tc[0][k] = 3'b101;
        do_load();
        tlen[0] = 4;
        for (int c = 1; c <= 6; c++) begin
            tick();
            e_ack  = (c <= 4) ? 4'b0001 : 4'b0000;
            e_we   = (c == 2) || (c == 5);
            e_done = (c == 5) ? 4'b0001 : 4'b0000;
            chk("clip_ack",  ack, e_ack);
            chk("clip_we",   writeEn, e_we);
            chk("clip_done", done, e_done);
            if (e_we)
                chk("clip_pix", {oX, oY, oColor}, {(c == 2) ? 8'd5 : 8'd7, 7'd5, 3'b101});
        end

        // Game over on the 2nd pixel of a 10-pixel sprite
        clear_tables();
        for (int k = 0; k < 10; k++) begin
            tx[0][k] = XW'(20 + k); ty[0][k] = 7'd30; tc[0][k] = 3'b001; tl[0][k] = (k == 9);
        end
        do_load();
        tlen[0] = 10;
        tick();
        chk("go_ack_first", ack, 4'b0001);
        tick();
        chk("go_pix0", {writeEn, oX, oY}, {1'b1, 8'd20, 7'd30});
        game_over = 1'b1;
        #1;
        chk("go_ack_drop", ack, 4'b0000);
        tick();
        chk("go_no_we",   writeEn, 0);
        chk("go_no_done", done, 0);
        sweep_check("fill", 3'b100, 1'b0);
        nw = 0;
        repeat (5) begin
            tick();
            if (writeEn || ack != '0) nw++;
        end
        chk("over_quiet", nw, 0);

        // New game, then reset halfway through the clear
        game_over = 1'b0;
        tlen[0]   = 0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        nw = 0;
        for (int c = 0; c < 9600; c++) begin
            tick();
            if (writeEn) nw++;
            if (c == 0) chk("reclear_first", {writeEn, oX, oY, oColor}, {1'b1, 8'd0, 7'd0, 3'b000});
        end
        chk("reclear_writes", nw, 9600);
        chk("reclear_last", {oX, oY}, {8'd159, 7'd59});
        reset = 1'b1;
        tick();
        chk("midrst_we",    writeEn, 0);
        chk("midrst_cdone", clear_done, 0);
        chk("midrst_pix",   {oX, oY, oColor}, 0);
        chk("midrst_state", dut.state_q, IDLE);
        reset = 1'b0;
        nw = 0;
        repeat (300) begin
            tick();
            if (writeEn || clear_done) nw++;
        end
        chk("midrst_quiet", nw, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("restart_we", {writeEn, oX, oY}, {1'b1, 8'd0, 7'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
